// File: rtl/ca90_hier_pkg.sv
// Shared types and helpers for the sequential hierarchical CA90 base-HV generator.
package ca90_hier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } ca90_state_e;

    // Width of the input to layer k; layer k writes the next seed_width<<k bits.
    function automatic int ca90_layer_width(input int seed_width, input int k);
        return seed_width << k;
    endfunction

endpackage

// File: rtl/ca90_layer_step.sv
// One CA90 layer: circular neighbour XOR over the low W = SeedWidth<<layer bits.
module ca90_layer_step
    import ca90_hier_pkg::*;
#(
    parameter int HVDimension = 512,
    parameter int SeedWidth = 32,
    localparam int NumLayers = $clog2(HVDimension / SeedWidth),
    localparam int LayerCntWidth = $clog2(NumLayers + 1)
) (
    input  logic [HVDimension-1:0]   vec,
    input  logic [LayerCntWidth-1:0] layer,
    output logic [HVDimension/2-1:0] step
);

    localparam int Half = HVDimension / 2;

    logic [Half-1:0] cand [NumLayers];

    for (genvar k = 0; k < NumLayers; k++) begin : g_layer
        localparam int W = ca90_layer_width(SeedWidth, k);
        logic [W-1:0] v;
        logic [W-1:0] res;
        assign v = vec[W-1:0];
        // Rotate right brings v[i+1] to bit i, rotate left brings v[i-1]; wrap is at W.
        assign res = {v[0], v[W-1:1]} ^ {v[W-2:0], v[W-1]};
        if (W == Half) begin : g_full
            assign cand[k] = res;
        end else begin : g_part
            assign cand[k] = {{(Half - W){1'b0}}, res};
        end
    end

    always_comb begin
        step = '0;
        for (int k = 0; k < NumLayers; k++) begin
            if (layer == LayerCntWidth'(k)) begin
                step = cand[k];
            end
        end
    end

endmodule

// File: rtl/ca90_hier_base_seq.sv
// Sequential hierarchical CA90 base-HV generator: one layer per cycle, seed/HV valid-ready.
// Optional CA90_HIER_ZERO_CHECK_EN rejects an all-zero seed with a one-cycle err_o pulse.
module ca90_hier_base_seq
    import ca90_hier_pkg::*;
#(
    parameter int HVDimension = 512,
    parameter int SeedWidth = 32,
    localparam int NumLayers = $clog2(HVDimension / SeedWidth),
    localparam int LayerCntWidth = $clog2(NumLayers + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [SeedWidth-1:0]     seed_i,
    input  logic [LayerCntWidth-1:0] num_layers_i,
    input  logic                     seed_valid_i,
    output logic                     seed_ready_o,
    output logic [HVDimension-1:0]   hv_o,
    output logic                     hv_valid_o,
    input  logic                     hv_ready_i,
    output logic                     err_o,
    output ca90_state_e              state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // a producer holds valid and data stable until that edge.

    ca90_state_e state_q, state_d;
    logic [LayerCntWidth-1:0] cnt_q, target_q, target_in;
    logic [HVDimension-1:0]   hv_q;
    logic [HVDimension/2-1:0] step;
    logic accept, zero_reject, load;

    assign accept = seed_valid_i & seed_ready_o;
    assign target_in = (num_layers_i > LayerCntWidth'(NumLayers)) ? LayerCntWidth'(NumLayers)
                                                                  : num_layers_i;

`ifdef CA90_HIER_ZERO_CHECK_EN
    logic err_q;
    assign zero_reject = accept && (seed_i == '0);
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= zero_reject;
        end
    end
    assign err_o = err_q;
`else
    assign zero_reject = 1'b0;
    assign err_o = 1'b0;
`endif

    assign load = accept && !zero_reject;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (load) state_d = (target_in != '0) ? GEN : DONE;
            GEN:  if (cnt_q == target_q - LayerCntWidth'(1)) state_d = DONE;
            DONE: if (hv_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        seed_ready_o = (state_q == IDLE);
        hv_valid_o = (state_q == DONE);
    end

    ca90_layer_step #(
        .HVDimension(HVDimension),
        .SeedWidth(SeedWidth)
    ) u_step (
        .vec(hv_q),
        .layer(cnt_q),
        .step(step)
    );

    // Bits above the current width are still zero, so OR-ing the shifted layer writes [2W-1:W].
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hv_q <= '0;
            cnt_q <= '0;
            target_q <= '0;
        end else if (state_q == IDLE && load) begin
            hv_q <= HVDimension'(seed_i);
            cnt_q <= '0;
            target_q <= target_in;
        end else if (state_q == GEN) begin
            hv_q <= hv_q | (HVDimension'(step) << ca90_layer_width(SeedWidth, int'(cnt_q)));
            cnt_q <= cnt_q + LayerCntWidth'(1);
        end
    end

    assign hv_o = hv_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_ca90_hier_base_seq.sv
// Bench for ca90_hier_base_seq at default parameters; honours CA90_HIER_ZERO_CHECK_EN.
module tb_ca90_hier_base_seq;
    import ca90_hier_pkg::*;

    localparam int HV = 512;
    localparam int SW = 32;
    localparam int NL = 4;
    localparam int LCW = 3;

    logic clk, rst_n;
    logic [SW-1:0] seed;
    logic [LCW-1:0] num_layers;
    logic seed_valid, seed_ready;
    logic [HV-1:0] hv;
    logic hv_valid, hv_ready, err;
    ca90_state_e state;

    logic [HV-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    ca90_hier_base_seq dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .seed_i(seed),
        .num_layers_i(num_layers),
        .seed_valid_i(seed_valid),
        .seed_ready_o(seed_ready),
        .hv_o(hv),
        .hv_valid_o(hv_valid),
        .hv_ready_i(hv_ready),
        .err_o(err),
        .state_o(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [HV-1:0] got, input logic [HV-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model written from the CA90 definition with explicit modulo wrap.
    function automatic logic [HV-1:0] golden(input logic [SW-1:0] s, input int layers);
        logic [HV-1:0] v;
        int w;
        v = '0;
        v[SW-1:0] = s;
        for (int k = 0; k < layers; k++) begin
            w = SW << k;
            for (int i = 0; i < w; i++) begin
                v[w + i] = v[(i + 1) % w] ^ v[(i - 1 + w) % w];
            end
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n && hv_valid && hv_ready) begin
            if (exp_q.size() == 0) check("unexpected_hv", HV'(1), HV'(0));
            else check("hv", hv, exp_q.pop_front());
        end
    end

    task automatic send(input logic [SW-1:0] s, input int layers, output logic [HV-1:0] e);
        int t, lat;
        t = (layers > NL) ? NL : layers;
        e = golden(s, t);
        @(posedge clk); #1;
        check("ready_idle", HV'(seed_ready), HV'(1));
        seed = s;
        num_layers = LCW'(layers);
        seed_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        seed_valid = 1'b0;
        seed = $urandom();
        num_layers = LCW'($urandom_range(0, 7));
        lat = 1;
        while (!hv_valid && lat < 16) begin
            check("busy_ready", HV'(seed_ready), HV'(0));
            @(posedge clk); #1;
            lat++;
        end
        check("latency", HV'(lat), HV'(t + 1));
        check("done_ready", HV'(seed_ready), HV'(0));
    endtask

    initial begin
        logic [HV-1:0] e;
        rst_n = 1'b0;
        seed_valid = 1'b0;
        hv_ready = 1'b1;
        seed = '0;
        num_layers = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hv", hv, HV'(0));
        check("rst_valid", HV'(hv_valid), HV'(0));
        check("rst_err", HV'(err), HV'(0));
        check("rst_state", HV'(state), HV'(IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", HV'(seed_ready), HV'(1));

        send(32'h0000_0001, 1, e);
        check("hv_const_l1", hv, HV'(64'h8000_0002_0000_0001));
        send(32'hDEAD_BEEF, 4, e);
        send($urandom() | 32'h1, 0, e);
        check("l0_upper_zero", hv >> SW, HV'(0));
        send($urandom() | 32'h1, 2, e);
        check("l2_upper_zero", hv >> 128, HV'(0));
        send($urandom() | 32'h1, 7, e);
        for (int n = 0; n < 4; n++) send($urandom() | 32'h1, $urandom_range(0, 7), e);

        // Back-pressure in DONE: output held, new requests ignored.
        @(posedge clk); #1;
        hv_ready = 1'b0;
        send(32'h1234_5678, 3, e);
        for (int n = 0; n < 10; n++) begin
            seed_valid = 1'b1;
            seed = $urandom();
            num_layers = LCW'($urandom_range(0, 7));
            @(posedge clk); #1;
            check("hold_valid", HV'(hv_valid), HV'(1));
            check("hold_hv", hv, e);
            check("hold_ready", HV'(seed_ready), HV'(0));
        end
        seed_valid = 1'b0;
        hv_ready = 1'b1;
        @(posedge clk); #1;
        check("release_ready", HV'(seed_ready), HV'(1));
        check("release_state", HV'(state), HV'(IDLE));

        // Reset during the second GEN cycle aborts the request.
        seed = 32'hCAFE_F00D;
        num_layers = LCW'(4);
        seed_valid = 1'b1;
        @(posedge clk); #1;
        seed_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_in_gen", HV'(state), HV'(GEN));
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_hv", hv, HV'(0));
        check("abort_valid", HV'(hv_valid), HV'(0));
        check("abort_state", HV'(state), HV'(IDLE));
        rst_n = 1'b1;
        send(32'hA5A5_0F0F, 4, e);

`ifdef CA90_HIER_ZERO_CHECK_EN
        @(posedge clk); #1;
        seed = '0;
        num_layers = LCW'(4);
        seed_valid = 1'b1;
        @(posedge clk); #1;
        seed_valid = 1'b0;
        check("zero_err", HV'(err), HV'(1));
        check("zero_state", HV'(state), HV'(IDLE));
        @(posedge clk); #1;
        check("zero_err_pulse", HV'(err), HV'(0));
        for (int n = 0; n < 6; n++) begin
            check("zero_no_valid", HV'(hv_valid), HV'(0));
            @(posedge clk); #1;
        end
`else
        send('0, 4, e);
        check("zero_hv", hv, HV'(0));
        check("zero_no_err", HV'(err), HV'(0));
`endif

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", HV'(exp_q.size()), HV'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
